test_bench: RTL and testbench

Avalon-MM on-chip RAM subsystem: a single 32-bit slave port backed by a synchronous, byte-enabled RAM. External Avalon-MM masters (bus-functional models in simulation, CPU masters in SOPC builds) write data and read it back with fixed, pipelined read latency. It is the slave side of the SOPC verification system.

---
 rtl/test_bench_pkg.sv | 22 ++
 rtl/onchip_ram.sv | 35 +++
 rtl/test_bench.sv | 102 ++++++++++
 tb/tb_test_bench.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/test_bench_pkg.sv
// Shared constants and types for the Avalon-MM on-chip RAM slave.
// TEST_BENCH_OUTREG_EN selects the two-cycle read latency build.
package test_bench_pkg;

    localparam int ADDR_W      = 16;
    localparam int DATA_W      = 32;
    localparam int SYMBOL_W    = 8;
    localparam int NUMSYMBOLS  = DATA_W / SYMBOL_W;
    localparam int DEPTH_WORDS = 1024;

`ifdef TEST_BENCH_OUTREG_EN
    localparam int READ_LATENCY = 2;
`else
    localparam int READ_LATENCY = 1;
`endif

    typedef enum logic [0:0] {
        ST_RESET,
        ST_READY
    } slave_state_e;

endpackage

// File: rtl/onchip_ram.sv
// Single-port synchronous RAM with per-symbol write enables and a registered read port.
// Contents are never reset.
module onchip_ram
    import test_bench_pkg::*;
#(
    parameter int RAM_DATA_W = 32,
    parameter int RAM_SYM_W  = 8,
    parameter int RAM_DEPTH  = 1024,
    parameter int RAM_IDX_W  = $clog2(RAM_DEPTH),
    parameter int RAM_NSYM   = RAM_DATA_W / RAM_SYM_W
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [RAM_IDX_W-1:0]  idx,
    input  logic [RAM_DATA_W-1:0] wdata,
    input  logic [RAM_NSYM-1:0]   be,
    output logic [RAM_DATA_W-1:0] q
);

    logic [RAM_NSYM-1:0][RAM_SYM_W-1:0] mem [RAM_DEPTH];
    logic [RAM_NSYM-1:0][RAM_SYM_W-1:0] wsym;

    assign wsym = wdata;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < RAM_NSYM; i++) begin
                if (be[i]) mem[idx][i] <= wsym[i];
            end
        end
        if (rd_en) q <= mem[idx];
    end

endmodule

// File: rtl/test_bench.sv
// Avalon-MM slave wrapping onchip_ram: waitrequest wake-up, command decode, read-valid pipeline.
// Define TEST_BENCH_OUTREG_EN for an extra read output register (latency 2).
module test_bench #(
    parameter int ADDR_W      = test_bench_pkg::ADDR_W,
    parameter int DATA_W      = test_bench_pkg::DATA_W,
    parameter int DEPTH_WORDS = test_bench_pkg::DEPTH_WORDS
) (
    input  logic                     clk_0,
    input  logic                     reset_n,
    input  logic [ADDR_W-1:0]        avs_address,
    input  logic                     avs_read,
    input  logic                     avs_write,
    input  logic [DATA_W-1:0]        avs_writedata,
    input  logic [DATA_W/8-1:0]      avs_byteenable,
    output logic                     avs_waitrequest,
    output logic [DATA_W-1:0]        avs_readdata,
    output logic                     avs_readdatavalid
);

    import test_bench_pkg::*;

    localparam int NSYM   = DATA_W / SYMBOL_W;
    localparam int IDX_W  = $clog2(DEPTH_WORDS);
    // Stage 1 is the RAM read register, the last stage drives readdatavalid.
    localparam int STAGES = READ_LATENCY + 1;

    slave_state_e      state, state_nxt;
    logic              acc, wr_en, rd_en;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] ram_q, rd_src;
    logic [STAGES:1]   vld_pipe;
    logic              unused_addr;

    // Upper address bits fold away so out-of-range addresses wrap.
    assign idx         = avs_address[IDX_W+1:2];
    assign unused_addr = ^{avs_address[ADDR_W-1:IDX_W+2], avs_address[1:0]};

    assign acc   = reset_n & ~avs_waitrequest & (avs_read | avs_write);
    assign wr_en = acc & avs_write;
    assign rd_en = acc & avs_read & ~avs_write;

    always_ff @(posedge clk_0) begin
        if (!reset_n) state <= ST_RESET;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RESET: state_nxt = ST_READY;
            ST_READY: state_nxt = ST_READY;
        endcase
    end

    always_ff @(posedge clk_0) begin
        if (!reset_n) avs_waitrequest <= 1'b1;
        else          avs_waitrequest <= (state_nxt != ST_READY);
    end

    always_ff @(posedge clk_0) begin
        if (!reset_n) vld_pipe <= '0;
        else          vld_pipe <= {vld_pipe[STAGES-1:1], rd_en};
    end

    onchip_ram #(
        .RAM_DATA_W (DATA_W),
        .RAM_SYM_W  (SYMBOL_W),
        .RAM_DEPTH  (DEPTH_WORDS),
        .RAM_IDX_W  (IDX_W),
        .RAM_NSYM   (NSYM)
    ) u_ram (
        .clk   (clk_0),
        .wr_en (wr_en),
        .rd_en (rd_en),
        .idx   (idx),
        .wdata (avs_writedata),
        .be    (avs_byteenable),
        .q     (ram_q)
    );

`ifdef TEST_BENCH_OUTREG_EN
    logic [DATA_W-1:0] out_stage;

    always_ff @(posedge clk_0) begin
        if (!reset_n)         out_stage <= '0;
        else if (vld_pipe[1]) out_stage <= ram_q;
    end

    assign rd_src = out_stage;
`else
    assign rd_src = ram_q;
`endif

    // Only loaded alongside a valid strobe, so the bus sees stable data otherwise.
    always_ff @(posedge clk_0) begin
        if (!reset_n)                avs_readdata <= '0;
        else if (vld_pipe[STAGES-1]) avs_readdata <= rd_src;
    end

    assign avs_readdatavalid = vld_pipe[STAGES];

endmodule

// File: tb/tb_test_bench.sv
// Directed bench for the Avalon-MM RAM slave; tracks the configured read latency.
module tb_test_bench;
    import test_bench_pkg::*;

    localparam int LAT = READ_LATENCY;

    logic        clk_0 = 1'b0;
    logic        reset_n;
    logic [15:0] avs_address;
    logic        avs_read, avs_write;
    logic [31:0] avs_writedata;
    logic [3:0]  avs_byteenable;
    logic        avs_waitrequest;
    logic [31:0] avs_readdata;
    logic        avs_readdatavalid;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int acc;

    logic [31:0] rd_q[$];
    int          rd_cyc[$];

    test_bench u_dut (
        .clk_0             (clk_0),
        .reset_n           (reset_n),
        .avs_address       (avs_address),
        .avs_read          (avs_read),
        .avs_write         (avs_write),
        .avs_writedata     (avs_writedata),
        .avs_byteenable    (avs_byteenable),
        .avs_waitrequest   (avs_waitrequest),
        .avs_readdata      (avs_readdata),
        .avs_readdatavalid (avs_readdatavalid)
    );

    always #5 clk_0 = ~clk_0;
    always @(posedge clk_0) cyc <= cyc + 1;

    always @(negedge clk_0) begin
        if (avs_readdatavalid === 1'b1) begin
            rd_q.push_back(avs_readdata);
            rd_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_0);
        #1;
    endtask

    task automatic flush();
        rd_q.delete();
        rd_cyc.delete();
    endtask

    task automatic wr(input logic [15:0] addr, input logic [31:0] data, input logic [3:0] be);
        avs_address    = addr;
        avs_writedata  = data;
        avs_byteenable = be;
        avs_write      = 1'b1;
        tick(1);
        avs_write      = 1'b0;
    endtask

    task automatic rd_one(input logic [15:0] addr, input logic [31:0] exp, input string tag);
        flush();
        avs_address = addr;
        avs_read    = 1'b1;
        tick(1);
        acc      = cyc;
        avs_read = 1'b0;
        tick(LAT + 3);
        check({tag, "_cnt"}, rd_q.size(), 1);
        if (rd_q.size() >= 1) begin
            check({tag, "_data"}, rd_q[0], exp);
            check({tag, "_lat"}, rd_cyc[0] - acc, LAT);
        end
        check({tag, "_hold"}, avs_readdata, exp);
        flush();
    endtask

    initial begin
        reset_n        = 1'b0;
        avs_address    = '0;
        avs_read       = 1'b0;
        avs_write      = 1'b0;
        avs_writedata  = '0;
        avs_byteenable = '0;

        // reset and waitrequest release
        tick(5);
        @(negedge clk_0);
        check("rst_wait", avs_waitrequest, 1);
        check("rst_vld", avs_readdatavalid, 0);
        check("rst_data", avs_readdata, 0);
        @(posedge clk_0); #1;
        reset_n = 1'b1;
        @(negedge clk_0);
        check("wait_hold", avs_waitrequest, 1);
        tick(1);
        check("wait_fall", avs_waitrequest, 0);

        // full-word writes then single reads
        for (int i = 0; i < 5; i++) wr(16'(i * 4), 32'h11111111 * (i + 1), 4'hF);
        for (int i = 0; i < 5; i++)
            rd_one(16'(i * 4), 32'h11111111 * (i + 1), $sformatf("word%0d", i));

        // partial and empty byte enables
        wr(16'h0020, 32'hAABBCCDD, 4'hF);
        wr(16'h0020, 32'h11223344, 4'b0101);
        rd_one(16'h0020, 32'hAA22CC44, "partial");
        wr(16'h0020, 32'hFFFFFFFF, 4'b0000);
        rd_one(16'h0020, 32'hAA22CC44, "be_none");

        // read and write together: write only
        flush();
        avs_address    = 16'h0024;
        avs_writedata  = 32'h12345678;
        avs_byteenable = 4'hF;
        avs_read       = 1'b1;
        avs_write      = 1'b1;
        tick(1);
        avs_read  = 1'b0;
        avs_write = 1'b0;
        tick(LAT + 3);
        check("rw_novld", rd_q.size(), 0);
        rd_one(16'h0024, 32'h12345678, "rw_wr");

        // read on the cycle right after a write to the same word
        wr(16'h0028, 32'hCAFEF00D, 4'hF);
        rd_one(16'h0028, 32'hCAFEF00D, "wr_then_rd");

        // back-to-back reads
        flush();
        avs_read = 1'b1;
        for (int i = 0; i < 5; i++) begin
            avs_address = 16'(i * 4);
            tick(1);
            if (i == 0) acc = cyc;
        end
        avs_read = 1'b0;
        tick(LAT + 3);
        check("b2b_cnt", rd_q.size(), 5);
        for (int i = 0; i < 5 && i < rd_q.size(); i++) begin
            check($sformatf("b2b_data%0d", i), rd_q[i], 32'h11111111 * (i + 1));
            check($sformatf("b2b_cyc%0d", i), rd_cyc[i], acc + LAT + i);
        end
        flush();

        // address wrap
        wr(16'h1000, 32'hDEADBEEF, 4'hF);
        rd_one(16'h0000, 32'hDEADBEEF, "wrap");

        // reset with reads in flight
        flush();
        avs_read = 1'b1;
        for (int k = 0; k < LAT; k++) begin
            avs_address = 16'(k * 4 + 4);
            tick(1);
        end
        avs_read = 1'b0;
        reset_n  = 1'b0;
        tick(2);
        check("rst_mid_data", avs_readdata, 0);
        check("rst_mid_wait", avs_waitrequest, 1);
        reset_n = 1'b1;
        tick(1);
        tick(LAT + 3);
        check("rst_mid_novld", rd_q.size(), 0);
        rd_one(16'h0004, 32'h22222222, "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
